exu_issue_ctrl: RTL and testbench

- Sequences the execute stage: owns the ID/EX stage valid bit, decides each cycle whether the ID/EX register loads, holds or takes a bubble, and hands completed results to MEM.
- Resolves load-use hazards, branch flushes, MEM back-pressure and multi-cycle ops on the external iterative MDU.
- Feeds the ID/EX register enable/clear pins and the forwarding unit's stage-valid qualifiers.

---
 rtl/exu_issue_ctrl.sv | 139 +++++++++++++
 tb/tb_exu_issue_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_issue_ctrl.sv
// Execute-stage issue controller: owns the ID/EX valid bit, steers the ID/EX
// register (load / hold / bubble), and sequences multi-cycle MDU operations.
module exu_issue_ctrl #(
    parameter int MDU_TIMEOUT = 64,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IDU_valid,
    output logic              IDU_ready,
    input  logic [4:0]        IDU_rs1,
    input  logic [4:0]        IDU_rs2,
    input  logic              IDU_use_rs1,
    input  logic              IDU_use_rs2,
    input  logic              IDU_mdu_op,
    input  logic [4:0]        EXU_rd,
    input  logic              EXU_mem_to_reg,
    input  logic              EXU_write_gpr,
    input  logic              BRANCH_PCSrc,
    input  logic              MDU_done,
    input  logic              MEM_ready,
    output logic              IDEX_load,
    output logic              IDEX_clear,
    output logic              EXU_valid,
    output logic              EXU_out_valid,
    output logic              MDU_start,
    output logic              EXU_timeout,
    output logic [PERF_W-1:0] PERF_stall_cnt,
    output logic [PERF_W-1:0] PERF_bubble_cnt,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MDU_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD     = 2'd2;
    localparam logic [1:0] ST_HALT     = 2'd3;

    localparam int TW = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(MDU_TIMEOUT - 1);

    logic [1:0]    state;
    logic          exu_valid_q;
    logic          mdu_pend;
    logic [TW-1:0] tmo_cnt;
    logic          timeout_q;

    logic empty;
    logic result_rdy;
    logic advance;
    logic flush;
    logic hazard;
    logic load_use;

    // Handshakes: ID hands over when IDU_valid & IDU_ready; EXU hands to MEM
    // when EXU_out_valid & MEM_ready ("advance"). Nothing moves otherwise.
    always_comb begin
        empty = (state == ST_RUN) && !exu_valid_q;
        case (state)
            ST_RUN:      result_rdy = exu_valid_q && (!mdu_pend || MDU_done);
            ST_MDU_WAIT: result_rdy = MDU_done;
            default:     result_rdy = 1'b1;
        endcase
    end

    assign advance = result_rdy && MEM_ready && (state != ST_HALT);
    assign flush   = advance && BRANCH_PCSrc;

    assign hazard = exu_valid_q && EXU_mem_to_reg && EXU_write_gpr &&
                    (EXU_rd != 5'd0) && IDU_valid &&
                    ((IDU_use_rs1 && (IDU_rs1 == EXU_rd)) ||
                     (IDU_use_rs2 && (IDU_rs2 == EXU_rd)));

    assign load_use = advance && !flush && hazard;

    // A bubble is loaded on flush, load-use, and whenever the stage frees up
    // with nothing to take from ID; the clear always wins over the load.
    assign IDU_ready     = empty || (advance && !load_use);
    assign IDEX_clear    = rst || flush || load_use || ((empty || advance) && !IDU_valid);
    assign IDEX_load     = !IDEX_clear && IDU_ready && IDU_valid;
    assign EXU_valid     = exu_valid_q;
    assign EXU_out_valid = result_rdy;
    assign MDU_start     = (state == ST_RUN) && exu_valid_q && mdu_pend;
    assign EXU_timeout   = timeout_q;
    assign dbg_state     = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_RUN;
            exu_valid_q     <= 1'b0;
            mdu_pend        <= 1'b0;
            tmo_cnt         <= '0;
            timeout_q       <= 1'b0;
            PERF_stall_cnt  <= '0;
            PERF_bubble_cnt <= '0;
        end else begin
            if (empty || advance)
                exu_valid_q <= IDEX_load;

            if (IDEX_load)
                mdu_pend <= IDU_mdu_op;
            else if (MDU_start || advance)
                mdu_pend <= 1'b0;

            if (IDU_valid && !IDU_ready)
                PERF_stall_cnt <= PERF_stall_cnt + PERF_W'(1);
            if (flush || load_use)
                PERF_bubble_cnt <= PERF_bubble_cnt + PERF_W'(1);

            case (state)
                ST_RUN: begin
                    if (exu_valid_q) begin
                        if (mdu_pend && !MDU_done) begin
                            state   <= ST_MDU_WAIT;
                            tmo_cnt <= '0;
                        end else if (!MEM_ready) begin
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_MDU_WAIT: begin
                    if (MDU_done) begin
                        state <= MEM_ready ? ST_RUN : ST_HOLD;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state     <= ST_HALT;
                        timeout_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                ST_HOLD: begin
                    if (MEM_ready)
                        state <= ST_RUN;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exu_issue_ctrl.sv
// Directed bench for exu_issue_ctrl: per-cycle control vectors plus an
// in-order retire scoreboard fed by a local model of the ID/EX register.
module tb_exu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        IDU_valid;
    logic        IDU_ready;
    logic [4:0]  IDU_rs1;
    logic [4:0]  IDU_rs2;
    logic        IDU_use_rs1;
    logic        IDU_use_rs2;
    logic        IDU_mdu_op;
    logic [4:0]  EXU_rd;
    logic        EXU_mem_to_reg;
    logic        EXU_write_gpr;
    logic        BRANCH_PCSrc;
    logic        MDU_done;
    logic        MEM_ready;
    logic        IDEX_load;
    logic        IDEX_clear;
    logic        EXU_valid;
    logic        EXU_out_valid;
    logic        MDU_start;
    logic        EXU_timeout;
    logic [31:0] PERF_stall_cnt;
    logic [31:0] PERF_bubble_cnt;
    logic [1:0]  dbg_state;

    logic [7:0]  id_id;
    logic [4:0]  id_rd;
    logic        id_ld;
    logic [7:0]  ex_id;
    logic [7:0]  exp_q[$];
    int          chk_cnt = 0;
    int          err_cnt = 0;

    exu_issue_ctrl #(.MDU_TIMEOUT(8), .PERF_W(32)) dut (
        .clk(clk), .rst(rst),
        .IDU_valid(IDU_valid), .IDU_ready(IDU_ready),
        .IDU_rs1(IDU_rs1), .IDU_rs2(IDU_rs2),
        .IDU_use_rs1(IDU_use_rs1), .IDU_use_rs2(IDU_use_rs2),
        .IDU_mdu_op(IDU_mdu_op),
        .EXU_rd(EXU_rd), .EXU_mem_to_reg(EXU_mem_to_reg), .EXU_write_gpr(EXU_write_gpr),
        .BRANCH_PCSrc(BRANCH_PCSrc), .MDU_done(MDU_done), .MEM_ready(MEM_ready),
        .IDEX_load(IDEX_load), .IDEX_clear(IDEX_clear),
        .EXU_valid(EXU_valid), .EXU_out_valid(EXU_out_valid),
        .MDU_start(MDU_start), .EXU_timeout(EXU_timeout),
        .PERF_stall_cnt(PERF_stall_cnt), .PERF_bubble_cnt(PERF_bubble_cnt),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [7:0] id, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic ld, input logic mdu);
        IDU_valid   = v;
        id_id       = id;
        id_rd       = rd;
        id_ld       = ld;
        IDU_rs1     = rs1;
        IDU_rs2     = rs2;
        IDU_use_rs1 = u1;
        IDU_use_rs2 = u2;
        IDU_mdu_op  = mdu;
    endtask

    task automatic clear_ex();
        ex_id          = 8'd0;
        EXU_rd         = 5'd0;
        EXU_mem_to_reg = 1'b0;
        EXU_write_gpr  = 1'b0;
    endtask

    // exp bits: {IDU_ready, IDEX_load, IDEX_clear, EXU_out_valid, MDU_start, EXU_valid}
    task automatic tick(input string tag, input logic [5:0] exp);
        logic [5:0] act;
        logic [7:0] exp_id;
        logic       load_s;
        logic       clear_s;
        @(negedge clk);
        act = {IDU_ready, IDEX_load, IDEX_clear, EXU_out_valid, MDU_start, EXU_valid};
        check(tag, 64'(act), 64'(exp));
        if (IDEX_load)
            exp_q.push_back(id_id);
        if (EXU_out_valid && MEM_ready && !EXU_timeout) begin
            exp_id = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hFF;
            check({tag, "_retire"}, 64'(ex_id), 64'(exp_id));
        end
        load_s  = IDEX_load;
        clear_s = IDEX_clear;
        @(posedge clk);
        #1;
        if (clear_s) begin
            clear_ex();
        end else if (load_s) begin
            ex_id          = id_id;
            EXU_rd         = id_rd;
            EXU_mem_to_reg = id_ld;
            EXU_write_gpr  = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] exp_id;
        rst          = 1'b1;
        MEM_ready    = 1'b1;
        BRANCH_PCSrc = 1'b0;
        MDU_done     = 1'b0;
        clear_ex();
        set_id(1, 8'd99, 5'd1, 5'd2, 5'd3, 1, 1, 0, 0);
        tick("reset", 6'b101000);
        check("reset_tmo", 64'(EXU_timeout), 64'd0);
        check("reset_stall", 64'(PERF_stall_cnt), 64'd0);
        check("reset_bubble", 64'(PERF_bubble_cnt), 64'd0);
        check("reset_state", 64'(dbg_state), 64'd0);
        rst = 1'b0;

        // back-to-back ALU ops
        set_id(1, 8'd1, 5'd1, 5'd2, 5'd3, 1, 1, 0, 0);
        tick("b2b_0", 6'b110000);
        set_id(1, 8'd2, 5'd2, 5'd3, 5'd4, 1, 1, 0, 0);
        tick("b2b_1", 6'b110101);
        set_id(1, 8'd3, 5'd3, 5'd1, 5'd2, 1, 1, 0, 0);
        tick("b2b_2", 6'b110101);
        set_id(0, 8'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        tick("b2b_3", 6'b101101);
        tick("b2b_4", 6'b101000);
        check("b2b_stall", 64'(PERF_stall_cnt), 64'd0);
        check("b2b_bubble", 64'(PERF_bubble_cnt), 64'd0);

        // load-use: LW x5 then ADD x6,x5,x1
        set_id(1, 8'd10, 5'd5, 5'd1, 5'd0, 1, 0, 1, 0);
        tick("lu_0", 6'b110000);
        set_id(1, 8'd11, 5'd6, 5'd5, 5'd1, 1, 1, 0, 0);
        tick("lu_1", 6'b001101);
        tick("lu_2", 6'b110000);
        set_id(0, 8'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        tick("lu_3", 6'b101101);
        tick("lu_4", 6'b101000);
        check("lu_stall", 64'(PERF_stall_cnt), 64'd1);
        check("lu_bubble", 64'(PERF_bubble_cnt), 64'd1);

        // no hazard: rd=x0, then unused rs fields matching rd
        set_id(1, 8'd20, 5'd0, 5'd1, 5'd0, 1, 0, 1, 0);
        tick("nh_0", 6'b110000);
        set_id(1, 8'd21, 5'd7, 5'd0, 5'd0, 1, 1, 0, 0);
        tick("nh_1", 6'b110101);
        set_id(1, 8'd22, 5'd5, 5'd1, 5'd0, 1, 0, 1, 0);
        tick("nh_2", 6'b110101);
        set_id(1, 8'd23, 5'd8, 5'd5, 5'd5, 0, 0, 0, 0);
        tick("nh_3", 6'b110101);
        set_id(0, 8'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        tick("nh_4", 6'b101101);
        tick("nh_5", 6'b101000);
        check("nh_bubble", 64'(PERF_bubble_cnt), 64'd1);

        // DIV with MDU_done on the 5th wait cycle, ADD waiting behind it
        set_id(1, 8'd30, 5'd9, 5'd1, 5'd2, 1, 1, 0, 1);
        tick("div_0", 6'b110000);
        set_id(1, 8'd31, 5'd10, 5'd1, 5'd2, 1, 1, 0, 0);
        tick("div_start", 6'b000011);
        for (int i = 0; i < 4; i++) tick("div_wait", 6'b000001);
        MDU_done = 1'b1;
        tick("div_done", 6'b110101);
        MDU_done = 1'b0;
        set_id(0, 8'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        tick("div_next", 6'b101101);
        tick("div_idle", 6'b101000);
        check("div_stall", 64'(PERF_stall_cnt), 64'd6);

        // single-cycle MDU op: done together with start
        set_id(1, 8'd32, 5'd11, 5'd1, 5'd2, 1, 1, 0, 1);
        tick("mdu1_0", 6'b110000);
        set_id(0, 8'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        MDU_done = 1'b1;
        tick("mdu1_1", 6'b101111);
        MDU_done = 1'b0;
        tick("mdu1_2", 6'b101000);

        // MEM back-pressure with a branch pending during HOLD
        set_id(1, 8'd40, 5'd12, 5'd1, 5'd2, 1, 1, 0, 0);
        tick("hold_0", 6'b110000);
        set_id(1, 8'd41, 5'd13, 5'd1, 5'd2, 1, 1, 0, 0);
        MEM_ready = 1'b0;
        tick("hold_1", 6'b000101);
        check("hold_state", 64'(dbg_state), 64'd2);
        BRANCH_PCSrc = 1'b1;
        tick("hold_2", 6'b000101);
        tick("hold_3", 6'b000101);
        MEM_ready = 1'b1;
        tick("flush", 6'b101101);
        BRANCH_PCSrc = 1'b0;
        set_id(0, 8'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        tick("flush_idle", 6'b101000);
        check("hold_stall", 64'(PERF_stall_cnt), 64'd9);
        check("hold_bubble", 64'(PERF_bubble_cnt), 64'd2);

        // MDU never answers: trap-halt after 8 wait cycles
        set_id(1, 8'd50, 5'd14, 5'd1, 5'd2, 1, 1, 0, 1);
        tick("tmo_0", 6'b110000);
        set_id(0, 8'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        tick("tmo_start", 6'b000011);
        for (int i = 0; i < 7; i++) tick("tmo_wait", 6'b000001);
        check("tmo_early", 64'(EXU_timeout), 64'd0);
        tick("tmo_wait8", 6'b000001);
        check("tmo_set", 64'(EXU_timeout), 64'd1);
        tick("halt_0", 6'b000101);
        MDU_done = 1'b1;
        tick("halt_1", 6'b000101);
        MDU_done = 1'b0;
        check("tmo_sticky", 64'(EXU_timeout), 64'd1);
        check("halt_state", 64'(dbg_state), 64'd3);
        exp_id = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hFF;
        check("halt_id", 64'(ex_id), 64'(exp_id));

        // asynchronous reset mid-HALT, sampled before any clock edge
        #2 rst = 1'b1;
        #1;
        check("arst_tmo", 64'(EXU_timeout), 64'd0);
        check("arst_vec", 64'({IDU_ready, IDEX_load, IDEX_clear, EXU_out_valid, MDU_start, EXU_valid}),
              64'(6'b101000));
        check("arst_state", 64'(dbg_state), 64'd0);
        check("arst_stall", 64'(PERF_stall_cnt), 64'd0);
        check("arst_bubble", 64'(PERF_bubble_cnt), 64'd0);
        clear_ex();
        tick("arst_hold", 6'b101000);
        rst = 1'b0;
        tick("post_rst", 6'b101000);
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
